// File: rtl/pulse_bcd_counter.sv
// pulse_bcd_counter: 4-digit BCD pulse counter with multiplexed active-low 7-seg display; define PULSE_CNT_SATURATE_EN to saturate at 9999 instead of rolling over
module pulse_bcd_counter #(
  parameter int REFRESH_DIV = 10000,
  parameter int DIV_W = 14
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PULSO,
  input  logic        CLR,
  output logic [15:0] COUNT,
  output logic        WRAP,
  output logic [3:0]  AN,
  output logic [6:0]  SEG
);
  typedef enum logic [1:0] {SCAN0, SCAN1, SCAN2, SCAN3} state_t;
  state_t state, state_n;
  logic pulso_q, inc, at_max, tick;
  logic [3:0] cy;
  logic [15:0] count_inc;
  logic [DIV_W-1:0] div;
  logic [3:0] digit, an_n;
  logic [6:0] seg_n;
  assign inc = PULSO & ~pulso_q;
  assign at_max = COUNT == 16'h9999;
  assign tick = div == DIV_W'(REFRESH_DIV - 1);
  assign cy[0] = 1'b1;
  for (genvar i = 0; i < 4; i++) begin : g_dig
    assign count_inc[4*i +: 4] = cy[i] ? (COUNT[4*i +: 4] == 4'd9 ? 4'd0 : COUNT[4*i +: 4] + 4'd1) : COUNT[4*i +: 4];
    if (i < 3) begin : g_cy
      assign cy[i+1] = cy[i] & (COUNT[4*i +: 4] == 4'd9);
    end
  end
  // previous PULSO level for rising-edge detection; keeps tracking during CLR
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) pulso_q <= 1'b0;
    else pulso_q <= PULSO;
  // BCD count with clear priority over a counted edge
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      COUNT <= '0;
      WRAP <= 1'b0;
    end else if (CLR) begin
      COUNT <= '0;
      WRAP <= 1'b0;
    end
`ifdef PULSE_CNT_SATURATE_EN
    else if (inc) begin
      if (at_max) WRAP <= 1'b1;
      else COUNT <= count_inc;
    end
`else
    else begin
      WRAP <= inc & at_max;
      if (inc) COUNT <= count_inc;
    end
`endif
  // refresh divider and scan state register
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      div <= '0;
      state <= SCAN0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      state <= state_n;
    end
  // next scan state, digit select and enable for the current state
  always_comb begin
    state_n = tick ? state_t'(state + 2'd1) : state;
    digit = state == SCAN0 ? COUNT[3:0] : state == SCAN1 ? COUNT[7:4] : state == SCAN2 ? COUNT[11:8] : COUNT[15:12];
    an_n = ~(4'b0001 << state);
  end
  // active-low segment decode {g..a}
  always_comb begin
    seg_n = 7'b1111111;
    case (digit)
      4'd0: seg_n = 7'b1000000;
      4'd1: seg_n = 7'b1111001;
      4'd2: seg_n = 7'b0100100;
      4'd3: seg_n = 7'b0110000;
      4'd4: seg_n = 7'b0011001;
      4'd5: seg_n = 7'b0010010;
      4'd6: seg_n = 7'b0000010;
      4'd7: seg_n = 7'b1111000;
      4'd8: seg_n = 7'b0000000;
      4'd9: seg_n = 7'b0010000;
      default: seg_n = 7'b1111111;
    endcase
  end
  // registered display drive, dark while in reset
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      AN <= 4'b1111;
      SEG <= 7'b1111111;
    end else begin
      AN <= an_n;
      SEG <= seg_n;
    end
endmodule

// File: tb/tb_pulse_bcd_counter.sv
// tb_pulse_bcd_counter: directed self-checking bench for pulse_bcd_counter with a 4-cycle refresh
module tb_pulse_bcd_counter;
  logic CLK = 1'b0, RESET, PULSO, CLR;
  logic [15:0] COUNT;
  logic WRAP;
  logic [3:0] AN;
  logic [6:0] SEG;
  int passed = 0, total = 0;
  pulse_bcd_counter #(.REFRESH_DIV(4), .DIV_W(2)) dut (
    .CLK(CLK), .RESET(RESET), .PULSO(PULSO), .CLR(CLR),
    .COUNT(COUNT), .WRAP(WRAP), .AN(AN), .SEG(SEG)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic pulses(input int n);
    repeat (n) begin
      PULSO = 1'b1;
      step(1);
      PULSO = 1'b0;
      step(1);
    end
  endtask
  task automatic see_digit(input string tag, input logic [3:0] an, input logic [6:0] seg);
    for (int i = 0; i < 20 && AN != an; i++) step(1);
    check({tag, "_an"}, 16'(AN), 16'(an));
    check({tag, "_seg"}, 16'(SEG), 16'(seg));
  endtask
  initial begin
    RESET = 1'b1;
    PULSO = 1'b0;
    CLR = 1'b0;
    #12;
    check("rst_count", COUNT, 16'h0000);
    check("rst_wrap", 16'(WRAP), 16'h0);
    check("rst_an", 16'(AN), 16'hF);
    check("rst_seg", 16'(SEG), 16'h7F);
    RESET = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      check($sformatf("scan_an%0d", k), 16'(AN), 16'(4'(~(4'b0001 << ((k - 1) / 4)))));
      check($sformatf("scan_seg%0d", k), 16'(SEG), 16'h40);
    end
    check("idle_count", COUNT, 16'h0000);
    PULSO = 1'b1;
    step(1);
    check("lat_one_edge", COUNT, 16'h0001);
    step(9);
    PULSO = 1'b0;
    step(1);
    check("long_pulse", COUNT, 16'h0001);
    pulses(4);
    check("five_pulses", COUNT, 16'h0005);
    pulses(4);
    check("to_0009", COUNT, 16'h0009);
    see_digit("nine_u", 4'b1110, 7'b0010000);
    pulses(10);
    check("to_0019", COUNT, 16'h0019);
    see_digit("one_t", 4'b1101, 7'b1111001);
    pulses(980);
    check("to_0999", COUNT, 16'h0999);
    pulses(1);
    check("carry_1000", COUNT, 16'h1000);
    pulses(8999);
    check("to_9999", COUNT, 16'h9999);
    check("wrap_idle", 16'(WRAP), 16'h0);
    PULSO = 1'b1;
    step(1);
`ifdef PULSE_CNT_SATURATE_EN
    check("sat_count", COUNT, 16'h9999);
    check("sat_wrap", 16'(WRAP), 16'h1);
    PULSO = 1'b0;
    step(3);
    check("sat_wrap_held", 16'(WRAP), 16'h1);
    pulses(2);
    check("sat_hold", COUNT, 16'h9999);
    check("sat_wrap_held2", 16'(WRAP), 16'h1);
`else
    check("roll_count", COUNT, 16'h0000);
    check("roll_wrap", 16'(WRAP), 16'h1);
    PULSO = 1'b0;
    step(1);
    check("roll_wrap_end", 16'(WRAP), 16'h0);
    check("roll_count2", COUNT, 16'h0000);
`endif
    CLR = 1'b1;
    step(1);
    CLR = 1'b0;
    check("clr_count", COUNT, 16'h0000);
    check("clr_wrap", 16'(WRAP), 16'h0);
    pulses(42);
    check("to_0042", COUNT, 16'h0042);
    CLR = 1'b1;
    PULSO = 1'b1;
    step(1);
    CLR = 1'b0;
    check("clr_vs_inc", COUNT, 16'h0000);
    step(3);
    check("held_after_clr", COUNT, 16'h0000);
    PULSO = 1'b0;
    step(1);
    pulses(1234);
    check("to_1234", COUNT, 16'h1234);
    see_digit("d0", 4'b1110, 7'b0011001);
    see_digit("d1", 4'b1101, 7'b0110000);
    see_digit("d2", 4'b1011, 7'b0100100);
    see_digit("d3", 4'b0111, 7'b1111001);
    step(1);
    #2 RESET = 1'b1;
    #1;
    check("async_count", COUNT, 16'h0000);
    check("async_an", 16'(AN), 16'hF);
    check("async_seg", 16'(SEG), 16'h7F);
    step(1);
    RESET = 1'b0;
    step(1);
    check("post_rst_an", 16'(AN), 16'hE);
    check("post_rst_seg", 16'(SEG), 16'h40);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
